// File: rtl/restoring_div16.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_FASTPATH_EN: divide-by-zero finishes in one cycle without iterating.
module restoring_div16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  // quo_q starts out holding the dividend; its MSB feeds R while quotient bits shift in at the LSB.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d = 1'b0;
        if (start) begin
          quo_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef DIV_ZERO_FASTPATH_EN
          // Zero divisor spends a single non-busy RUN cycle before DONE.
          if (divisor == '0) begin
            busy_d = 1'b0;
            cnt_d  = '0;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // R never exceeds WIDTH bits after the update, so only trial's sign bit is dropped.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
        end else begin
          rem_d = shifted[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = (dvs_q == '0);
        end
`ifdef DIV_ZERO_FASTPATH_EN
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = quo_q;
          cnt_d   = '0;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
